// File: rtl/simplerisc_decode_pipe.sv
// SimpleRISC decode stage: registered decode of instruction/PC into control bundle,
// delivered through a two-entry skid buffer with flush, illegal flagging and a saturating count.
module simplerisc_decode_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instruction,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic              isRet,
  output logic              isSt,
  output logic              isWb,
  output logic              isImmediate,
  output logic              isBeq,
  output logic              isBgt,
  output logic              isUbranch,
  output logic              isLd,
  output logic              isCall,
  output logic [4:0]        alusignals,
  output logic [REG_AW-1:0] rd,
  output logic [REG_AW-1:0] rs1,
  output logic [REG_AW-1:0] rs2,
  output logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] br_offset,
  output logic              illegal,
  output logic              illegal_seen,
  output logic [CNT_W-1:0]  decoded_cnt
);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic              is_ret;
    logic              is_st;
    logic              is_wb;
    logic              is_imm;
    logic              is_beq;
    logic              is_bgt;
    logic              is_ubr;
    logic              is_ld;
    logic              is_call;
    logic [4:0]        alu;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] br_offset;
    logic              illegal;
  } bundle_t;

  localparam logic [REG_AW-1:0] RA_REG  = {REG_AW{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  // Pure decode of one instruction word; nop and undefined opcodes leave every flag low.
  function automatic bundle_t decode_instr(input logic [31:0] ins, input logic [PC_W-1:0] pc);
    bundle_t b;
    b           = '0;
    b.pc        = pc;
    b.alu       = ins[31:27];
    b.rd        = REG_AW'(ins[25:22]);
    b.rs1       = REG_AW'(ins[21:18]);
    b.rs2       = REG_AW'(ins[17:14]);
    b.br_offset = DATA_W'($signed(ins[26:0]));
    case (ins[17:16])
      2'b01:   b.imm = DATA_W'(ins[15:0]);
      2'b10:   b.imm = DATA_W'({ins[15:0], 16'h0000});
      default: b.imm = DATA_W'($signed(ins[15:0]));
    endcase
    case (ins[31:27])
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12: begin
        b.is_wb  = 1'b1;
        b.is_imm = ins[26];
      end
      5'd5: begin
        b.is_imm = ins[26];
      end
      5'd13: begin
        b.is_wb = 1'b0;
      end
      5'd14: begin
        b.is_ld  = 1'b1;
        b.is_wb  = 1'b1;
        b.is_imm = ins[26];
      end
      5'd15: begin
        b.is_st  = 1'b1;
        b.is_imm = ins[26];
        b.rs2    = REG_AW'(ins[25:22]);
      end
      5'd16: begin
        b.is_beq = 1'b1;
      end
      5'd17: begin
        b.is_bgt = 1'b1;
      end
      5'd18: begin
        b.is_ubr = 1'b1;
      end
      5'd19: begin
        b.is_ubr  = 1'b1;
        b.is_call = 1'b1;
        b.is_wb   = 1'b1;
        b.rd      = RA_REG;
      end
      5'd20: begin
        b.is_ret = 1'b1;
        b.is_ubr = 1'b1;
        b.rs1    = RA_REG;
      end
      default: begin
        b.illegal = 1'b1;
      end
    endcase
    return b;
  endfunction

  bundle_t    decoded_s;
  bundle_t    main_r;
  bundle_t    skid_r;
  logic       main_valid_r;
  logic       skid_valid_r;
  logic       out_fire_s;
  logic [CNT_W-1:0] decoded_cnt_r;
  logic       illegal_seen_r;

  // Decode the incoming word every cycle; it is only captured on acceptance.
  always_comb begin
    decoded_s = decode_instr(instruction, in_pc);
  end

  assign out_fire_s = main_valid_r & out_ready;

  // Main/skid stages: skid only fills when main is stalled, and drains back into main first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      main_r       <= '0;
      skid_r       <= '0;
    end else if (flush) begin
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (skid_valid_r) begin
      if (out_fire_s) begin
        main_r       <= skid_r;
        skid_valid_r <= 1'b0;
      end
    end else if (!main_valid_r || out_ready) begin
      main_valid_r <= in_valid;
      if (in_valid) begin
        main_r <= decoded_s;
      end
    end else if (in_valid) begin
      skid_r       <= decoded_s;
      skid_valid_r <= 1'b1;
    end
  end

  // Delivery statistics; flush deliberately leaves these alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      decoded_cnt_r  <= '0;
      illegal_seen_r <= 1'b0;
    end else begin
      if (out_fire_s && (decoded_cnt_r != CNT_MAX)) begin
        decoded_cnt_r <= decoded_cnt_r + CNT_W'(1'b1);
      end
      if (out_fire_s && main_r.illegal) begin
        illegal_seen_r <= 1'b1;
      end
    end
  end

  assign in_ready     = ~skid_valid_r;
  assign out_valid    = main_valid_r;
  assign out_pc       = main_r.pc;
  assign isRet        = main_r.is_ret;
  assign isSt         = main_r.is_st;
  assign isWb         = main_r.is_wb;
  assign isImmediate  = main_r.is_imm;
  assign isBeq        = main_r.is_beq;
  assign isBgt        = main_r.is_bgt;
  assign isUbranch    = main_r.is_ubr;
  assign isLd         = main_r.is_ld;
  assign isCall       = main_r.is_call;
  assign alusignals   = main_r.alu;
  assign rd           = main_r.rd;
  assign rs1          = main_r.rs1;
  assign rs2          = main_r.rs2;
  assign imm          = main_r.imm;
  assign br_offset    = main_r.br_offset;
  assign illegal      = main_r.illegal;
  assign illegal_seen = illegal_seen_r;
  assign decoded_cnt  = decoded_cnt_r;

endmodule

// File: tb/tb_simplerisc_decode_pipe.sv
// Directed bench for simplerisc_decode_pipe: a reference decoder feeds a scoreboard queue
// whose depth also predicts out_valid/in_ready; a CNT_W=2 twin checks counter saturation.
module tb_simplerisc_decode_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] instruction, in_pc;

  logic        in_ready, out_valid, isRet, isSt, isWb, isImmediate, isBeq, isBgt, isUbranch, isLd, isCall;
  logic [31:0] out_pc, imm, br_offset;
  logic [4:0]  alusignals;
  logic [3:0]  rd, rs1, rs2;
  logic        illegal, illegal_seen;
  logic [15:0] decoded_cnt;

  logic        in_ready_b, out_valid_b, isRet_b, isSt_b, isWb_b, isImm_b, isBeq_b, isBgt_b, isUbr_b, isLd_b, isCall_b;
  logic [31:0] out_pc_b, imm_b, br_offset_b;
  logic [4:0]  alusignals_b;
  logic [3:0]  rd_b, rs1_b, rs2_b;
  logic        illegal_b, illegal_seen_b;
  logic [1:0]  decoded_cnt_b;

  always #5 clk = ~clk;

  simplerisc_decode_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .isRet(isRet), .isSt(isSt), .isWb(isWb), .isImmediate(isImmediate),
    .isBeq(isBeq), .isBgt(isBgt), .isUbranch(isUbranch), .isLd(isLd), .isCall(isCall),
    .alusignals(alusignals), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .br_offset(br_offset),
    .illegal(illegal), .illegal_seen(illegal_seen), .decoded_cnt(decoded_cnt)
  );

  simplerisc_decode_pipe #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .instruction(instruction), .in_pc(in_pc), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_pc(out_pc_b), .isRet(isRet_b), .isSt(isSt_b), .isWb(isWb_b), .isImmediate(isImm_b),
    .isBeq(isBeq_b), .isBgt(isBgt_b), .isUbranch(isUbr_b), .isLd(isLd_b), .isCall(isCall_b),
    .alusignals(alusignals_b), .rd(rd_b), .rs1(rs1_b), .rs2(rs2_b), .imm(imm_b),
    .br_offset(br_offset_b), .illegal(illegal_b), .illegal_seen(illegal_seen_b),
    .decoded_cnt(decoded_cnt_b)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [8:0]  flags;
    logic [4:0]  alu;
    logic [11:0] regs;
    logic [31:0] imm;
    logic [31:0] br;
    logic        ill;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] cnt_m;
  logic [1:0]  cnt2_m;
  logic        seen_m;
  bit          known = 1'b0;
  bit          zero_chk = 1'b0;

  // Reference decoder written from the opcode table.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    logic [4:0] op;
    logic r, s, w, i, q, g, u, l, c;
    logic [3:0] f_rd, f_rs1, f_rs2;
    logic [31:0] iv;
    op = ins[31:27];
    r = (op == 5'd20);
    s = (op == 5'd15);
    q = (op == 5'd16);
    g = (op == 5'd17);
    l = (op == 5'd14);
    c = (op == 5'd19);
    u = (op == 5'd18) || c || r;
    w = ((op <= 5'd12) && (op != 5'd5)) || l || c;
    i = ((op <= 5'd15) && (op != 5'd13)) ? ins[26] : 1'b0;
    f_rd  = c ? 4'hF : ins[25:22];
    f_rs1 = r ? 4'hF : ins[21:18];
    f_rs2 = s ? ins[25:22] : ins[17:14];
    if (ins[17:16] == 2'b01)      iv = {16'h0000, ins[15:0]};
    else if (ins[17:16] == 2'b10) iv = {ins[15:0], 16'h0000};
    else                          iv = {{16{ins[15]}}, ins[15:0]};
    e.pc    = pc;
    e.flags = {r, s, w, i, q, g, u, l, c};
    e.alu   = op;
    e.regs  = {f_rd, f_rs1, f_rs2};
    e.imm   = iv;
    e.br    = {{5{ins[26]}}, ins[26:0]};
    e.ill   = (op >= 5'd21);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: compare at negedge against the model, advance the model, then cross the posedge.
  task automatic cycle();
    exp_t e;
    bit   can_acc;
    @(negedge clk);
    if (!rst_n) begin
      @(posedge clk); #1;
      sb_q.delete();
      cnt_m    = 16'd0;
      cnt2_m   = 2'd0;
      seen_m   = 1'b0;
      known    = 1'b1;
      zero_chk = 1'b1;
    end else begin
      if (known) begin
        can_acc = (sb_q.size() < 2);
        chk("out_valid", 64'(out_valid), 64'(sb_q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(can_acc));
        chk("decoded_cnt", 64'(decoded_cnt), 64'(cnt_m));
        chk("decoded_cnt_sat", 64'(decoded_cnt_b), 64'(cnt2_m));
        chk("illegal_seen", 64'(illegal_seen), 64'(seen_m));
        if (zero_chk) begin
          chk("rst_bundle", 64'({out_pc, isRet, isSt, isWb, isImmediate, isBeq, isBgt, isUbranch,
                                 isLd, isCall, alusignals, rd, rs1, rs2}), 64'd0);
          chk("rst_imm_br", {imm, br_offset}, 64'd0);
          chk("rst_illegal", 64'(illegal), 64'd0);
          zero_chk = 1'b0;
        end
        if (sb_q.size() > 0) begin
          e = sb_q[0];
          chk("out_pc", 64'(out_pc), 64'(e.pc));
          chk("flags", 64'({isRet, isSt, isWb, isImmediate, isBeq, isBgt, isUbranch, isLd, isCall}),
              64'(e.flags));
          chk("alusignals", 64'(alusignals), 64'(e.alu));
          chk("regs", 64'({rd, rs1, rs2}), 64'(e.regs));
          chk("imm", 64'(imm), 64'(e.imm));
          chk("br_offset", 64'(br_offset), 64'(e.br));
          chk("illegal", 64'(illegal), 64'(e.ill));
          if (out_ready) begin
            void'(sb_q.pop_front());
            if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
            if (cnt2_m != 2'd3) cnt2_m = cnt2_m + 2'd1;
            if (e.ill) seen_m = 1'b1;
          end
        end
        if (flush) sb_q.delete();
        else if (in_valid && can_acc) sb_q.push_back(model(instruction, in_pc));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    in_valid    = v;
    instruction = ins;
    in_pc       = pc;
    out_ready   = ordy;
    flush       = fl;
    cycle();
  endtask

  initial begin
    logic [31:0] rnd;
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // add r1,r2,.. then add r1,r2,r3 streamed
    drive(1'b1, 32'h0048_8000, 32'h0000_0100, 1'b1, 1'b0);
    drive(1'b1, 32'h0048_C000, 32'h0000_0104, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // immediate modifiers
    drive(1'b1, 32'h0400_0000 | 32'h0000_FFFF, 32'h0000_0110, 1'b1, 1'b0);
    drive(1'b1, 32'h0400_0000 | 32'h0001_FFFF, 32'h0000_0114, 1'b1, 1'b0);
    drive(1'b1, 32'h0400_0000 | 32'h0002_ABCD, 32'h0000_0118, 1'b1, 1'b0);
    drive(1'b1, 32'h0400_0000 | 32'h0003_8001, 32'h0000_011C, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // opcode sweep with random operand bits
    for (int op = 0; op < 32; op++) begin
      rnd = $urandom();
      drive(1'b1, {5'(op), rnd[26:0]}, 32'h0000_1000 + 32'(op * 4), 1'b1, 1'b0);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // backpressure: 4 inputs, 3 stalled cycles once the 2nd bundle is out
    drive(1'b1, 32'h0048_C000, 32'h0000_0200, 1'b1, 1'b0);
    drive(1'b1, 32'h7800_1234, 32'h0000_0204, 1'b1, 1'b0);
    drive(1'b1, 32'h8400_0010, 32'h0000_0208, 1'b0, 1'b0);
    drive(1'b1, 32'h9800_0000, 32'h0000_020C, 1'b0, 1'b0);
    drive(1'b1, 32'h9800_0000, 32'h0000_020C, 1'b0, 1'b0);
    drive(1'b1, 32'h9800_0000, 32'h0000_020C, 1'b1, 1'b0);
    drive(1'b1, 32'h9800_0000, 32'h0000_020C, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // flush with skid full and a new input offered
    drive(1'b1, 32'h7000_0001, 32'h0000_0300, 1'b0, 1'b0);
    drive(1'b1, 32'h7000_0002, 32'h0000_0304, 1'b0, 1'b0);
    drive(1'b1, 32'h7000_0003, 32'h0000_0308, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    // flush coinciding with an output handshake
    drive(1'b1, 32'hA800_0000, 32'h0000_0310, 1'b0, 1'b0);
    drive(1'b1, 32'h7000_0005, 32'h0000_0314, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b1, 32'h0048_C000, 32'h0000_0318, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // saturation of the 2-bit twin after a fresh reset
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'h0048_C000 + 32'(k), 32'h0000_0400 + 32'(k * 4), 1'b1, 1'b0);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // mid-stream reset with both stages full; reset beats flush and handshakes
    drive(1'b1, 32'hA000_0000, 32'h0000_0500, 1'b0, 1'b0);
    drive(1'b1, 32'hA000_0000, 32'h0000_0504, 1'b0, 1'b0);
    rst_n = 1'b0;
    drive(1'b1, 32'h9800_0000, 32'h0000_0508, 1'b1, 1'b1);
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
